// File: rtl/isp_yuv444to422_if.sv
// Pixel stream bundle for the 4:4:4 to 4:2:2 converter: 4:4:4 input side and 4:2:2 output side.
interface isp_yuv444to422_if;
  localparam int unsigned PW = 8;

  logic          in_href;
  logic          in_vsync;
  logic [PW-1:0] in_y;
  logic [PW-1:0] in_u;
  logic [PW-1:0] in_v;
  logic          in_avg_en;

  logic          out_href;
  logic          out_vsync;
  logic [PW-1:0] out_y;
  logic [PW-1:0] out_c;
  logic          out_c_is_v;
  logic          out_len_err;

  // Upstream/source side.
  modport master (
    output in_href, in_vsync, in_y, in_u, in_v, in_avg_en,
    input  out_href, out_vsync, out_y, out_c, out_c_is_v, out_len_err
  );

  // Converter side.
  modport slave (
    input  in_href, in_vsync, in_y, in_u, in_v, in_avg_en,
    output out_href, out_vsync, out_y, out_c, out_c_is_v, out_len_err
  );
endinterface

// File: rtl/isp_yuv444to422.sv
// YUV 4:4:4 -> 4:2:2 horizontal chroma decimation by pixel pairs, fixed 2-cycle latency,
// optional round-half-up pair averaging and a sticky line-length mismatch flag.
module isp_yuv444to422 #(
  parameter int unsigned WIDTH  = 1280,
  parameter int unsigned HEIGHT = 960
) (
  input logic                pclk,
  input logic                rst_n,
  isp_yuv444to422_if.slave   bus
);
  localparam int unsigned PW  = 8;
  localparam int unsigned SW  = PW + 1;
  localparam int unsigned CW  = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  // Reject geometries the pairing and length check cannot handle.
  if (WIDTH < 2 || HEIGHT < 1) begin : g_param_chk
    $error("isp_yuv444to422: WIDTH must be >= 2 and HEIGHT >= 1");
  end

  logic          phase;
  logic          avg_mode;
  logic [CW-1:0] pix_cnt;
  logic          len_err;

  logic          s1_href;
  logic          s1_vsync;
  logic          s1_phase;
  logic [PW-1:0] s1_y;
  logic [PW-1:0] s1_u;
  logic [PW-1:0] s1_v;
  logic [PW-1:0] v_hold;

  logic          vsync_rise_c;
  logic          href_fall_c;
  logic          pair_c;
  logic          len_mism_c;
  logic [SW-1:0] u_sum_c;
  logic [SW-1:0] v_sum_c;
  logic [PW-1:0] u_avg_c;
  logic [PW-1:0] v_avg_c;
  logic [PW-1:0] u_pick_c;
  logic [PW-1:0] v_pick_c;

  // Edge detects, pair detection and chroma selection. A pending even pixel pairs only with
  // an odd pixel on the very next cycle; otherwise it is a lone trailing pixel and keeps U0.
  always_comb begin
    vsync_rise_c = bus.in_vsync & ~s1_vsync;
    href_fall_c  = s1_href & ~bus.in_href;
    pair_c       = s1_href & ~s1_phase & bus.in_href;
    len_mism_c   = href_fall_c & (pix_cnt != WIDTH_C);
    u_sum_c      = {1'b0, s1_u} + {1'b0, bus.in_u} + SW'(1);
    v_sum_c      = {1'b0, s1_v} + {1'b0, bus.in_v} + SW'(1);
    u_avg_c      = PW'(u_sum_c >> 1);
    v_avg_c      = PW'(v_sum_c >> 1);
    u_pick_c     = s1_u;
    v_pick_c     = s1_v;
    if (pair_c && avg_mode) begin
      u_pick_c = u_avg_c;
      v_pick_c = v_avg_c;
    end
  end

  // Frame-level state: chroma mode, in-line phase, pixel counter and sticky length flag.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      avg_mode <= 1'b0;
      phase    <= 1'b0;
      pix_cnt  <= '0;
      len_err  <= 1'b0;
    end else begin
      if (vsync_rise_c) begin
        avg_mode <= bus.in_avg_en;
      end
      phase <= bus.in_href ? ~phase : 1'b0;
      if (bus.in_href) begin
        pix_cnt <= (pix_cnt == CNT_MAX) ? pix_cnt : pix_cnt + CW'(1);
      end else begin
        pix_cnt <= '0;
      end
      len_err <= (vsync_rise_c ? 1'b0 : len_err) | len_mism_c;
    end
  end

  // First pipeline stage: hold the current input pixel one cycle.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_href  <= 1'b0;
      s1_vsync <= 1'b0;
      s1_phase <= 1'b0;
      s1_y     <= '0;
      s1_u     <= '0;
      s1_v     <= '0;
      v_hold   <= '0;
    end else begin
      s1_href  <= bus.in_href;
      s1_vsync <= bus.in_vsync;
      s1_phase <= phase;
      s1_y     <= bus.in_y;
      s1_u     <= bus.in_u;
      s1_v     <= bus.in_v;
      if (pair_c) begin
        v_hold <= v_pick_c;
      end
    end
  end

  // Output stage: U slot for the even pixel, held V slot for the odd pixel, zero when idle.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_href    <= 1'b0;
      bus.out_vsync   <= 1'b0;
      bus.out_y       <= '0;
      bus.out_c       <= '0;
      bus.out_c_is_v  <= 1'b0;
      bus.out_len_err <= 1'b0;
    end else begin
      bus.out_href    <= s1_href;
      bus.out_vsync   <= s1_vsync;
      bus.out_len_err <= (vsync_rise_c ? 1'b0 : len_err) | len_mism_c;
      if (!s1_href) begin
        bus.out_y      <= '0;
        bus.out_c      <= '0;
        bus.out_c_is_v <= 1'b0;
      end else if (!s1_phase) begin
        bus.out_y      <= s1_y;
        bus.out_c      <= u_pick_c;
        bus.out_c_is_v <= 1'b0;
      end else begin
        bus.out_y      <= s1_y;
        bus.out_c      <= v_hold;
        bus.out_c_is_v <= 1'b1;
      end
    end
  end
endmodule

// File: doc/isp_yuv444to422.md
# isp_yuv444to422

Converts the 8-bit YUV 4:4:4 stream from the colour-space conversion stage into 8-bit YUV 4:2:2 with one luma and one interleaved chroma sample per pixel. Horizontal chroma is decimated by pixel pairs, with optional pair averaging. The block sits directly downstream of the RGB-to-YUV stage and feeds the output formatter. It also flags lines whose length differs from WIDTH.

## Interface
- WIDTH, 1280, expected active pixels per line; used only by the line-length check.
- HEIGHT, 960, informational; not used in logic.
- pclk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- in_href  in  1  line-valid; one pixel per cycle while high.
- in_vsync  in  1  frame sync; the rising edge marks frame start.
- in_y, in_u, in_v  in  8 each  YUV 4:4:4 pixel; U/V are offset-binary, centred at 128.
- in_avg_en  in  1  chroma mode.
  - 1: average each pair.
  - 0: take the even pixel's chroma.
  - Sampled only at the in_vsync rising edge.
- out_href  out  1  in_href delayed 2 cycles.
- out_vsync  out  1  in_vsync delayed 2 cycles.
- out_y  out  8  luma.
- out_c  out  8  chroma: U on even output pixels, V on odd output pixels.
- out_c_is_v  out  1  1 when out_c carries V.
- out_len_err  out  1  sticky line-length mismatch flag.

## Operation
- avg_mode register: loads in_avg_en on each in_vsync rising edge; holds for the whole frame; reset value 0.
- In-line phase bit: clears when in_href is low and toggles on every in_href-high cycle.
- Phase 0 (even pixel): capture Y0, U0, V0.
- Phase 1 (odd pixel):
  - Chroma sums are 9-bit.
  - avg_mode=1: Uc = (U0+U1+1)>>1 and Vc = (V0+V1+1)>>1, round-half-up, always within 0..255.
  - avg_mode=0: Uc = U0 and Vc = V0.
- Emission per pair: the even output pixel carries (Y0, Uc, is_v=0); the odd output pixel carries (Y1, Vc, is_v=1).
- Odd-length line: when in_href falls while a phase-0 pixel is pending, the last pixel is emitted as (Ylast, U0, is_v=0). Averaging treats it as pairing with itself, so the result is U0. No V slot follows. The phase bit resets.
- An in_href gap mid-line is a line end. The next high period starts a new line at phase 0.
- Line-length check:
  - A pixel counter (clog2(WIDTH)+1 bits, saturating) counts in_href-high cycles.
  - On each in_href falling edge, the count is compared against WIDTH. Any mismatch sets out_len_err.
  - out_len_err clears on the in_vsync rising edge. A mismatch on the same cycle as that clear wins, so the flag stays set.
- Whenever out_href=0: out_y, out_c and out_c_is_v are 0.

## Timing
- Reset value of every output and internal register is 0.
- Latency is fixed at 2 cycles for all pixels:
  - The input pixel at cycle t appears on the outputs at t+2.
  - out_href and out_vsync are the inputs delayed by 2 flops.
- Within a pair, with the even pixel at cycle t and the odd pixel at t+1:
  - Uc/Vc are registered at t+2.
  - The even output appears at t+2 and the odd output at t+3. Vc is held one extra cycle.
- Back-to-back lines with a single idle cycle between them are supported, with no pairing across the line boundary.
- Reset asserted mid-line clears all state immediately. The first line after reset release starts at phase 0.
- in_avg_en changes away from a vsync rising edge have no effect until the next frame.

## Test plan
- Reset, then one WIDTH=4 line with Y=10,20,30,40, U=100,102,50,51, V=200,201,0,3, avg=1.
  - Outputs at t+2..t+5: (10,101,U), (20,201,V), (30,51,U), (40,2,V).
  - out_len_err=0.
- Same stimulus with avg=0 -> chroma sequence 100, 200, 50, 0.
- Odd line of 3 pixels, U2=77, avg=1.
  - The third output is (Y2,77,is_v=0).
  - out_href falls 2 cycles after in_href; out_len_err=1 for WIDTH=4.
  - out_len_err clears on the next vsync rising edge.
- U0=U1=255, avg=1 -> Uc=255, with no wrap.
- in_avg_en toggled mid-frame -> no change until the next vsync rising edge, after which the new mode applies.
- rst_n pulsed low mid-pair -> all outputs 0 asynchronously; after release, the next line pairs from its first pixel.
